// File: rtl/act_skew_feeder.sv
// act_skew_feeder: buffers activation row vectors in a small FIFO and feeds
// them to the systolic array with a diagonal skew (lane i delayed i cycles),
// generating the compute enable and an end-of-batch done pulse.
module act_skew_feeder #(
    parameter int unsigned ARRAY_SIZE         = 2,
    parameter int unsigned COMPUTE_DATA_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH         = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0]  in_data,
    input  logic                                           in_last,
    input  logic                                           run,
    output logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0]  data_outs,
    output logic                                           compute,
    output logic                                           busy,
    output logic                                           done
);

    localparam int unsigned CDW   = COMPUTE_DATA_WIDTH;
    localparam int unsigned VEC_W = ARRAY_SIZE * CDW;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DRN_W = $clog2(ARRAY_SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // FIFO storage: {last, vector}
    logic [VEC_W:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DRN_W-1:0]     r_drn;
    logic [DRN_W-1:0]     w_drn_nxt;

    logic [ARRAY_SIZE-2:0] r_vld;
    logic                  r_compute;
    logic                  r_busy;
    logic                  r_done;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [VEC_W:0]       w_push_word;
    logic [VEC_W:0]       w_head;
    logic [VEC_W-1:0]     w_head_data;
    logic                 w_head_last;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign in_ready    = rst & ~w_full;
    assign w_push      = in_valid & in_ready;
    assign w_push_word = {in_last, in_data};
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_data = w_head[VEC_W-1:0];
    assign w_head_last = w_head[VEC_W];

    // FIFO data array write (payload only, no reset needed)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state and drain counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_drn   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drn   <= w_drn_nxt;
        end
    end

    // FSM next-state, drain counter and pop decision
    always_comb begin
        w_state_nxt = r_state;
        w_drn_nxt   = r_drn;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (run && !w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_last) begin
                        w_state_nxt = S_DRAIN;
                        w_drn_nxt   = DRN_W'(ARRAY_SIZE - 1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_drn == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_drn_nxt = r_drn - DRN_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-lane skew delay lines; lane i has i+1 stages, bubbles shift zeros
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
        logic [CDW-1:0] r_sh [0:gi];

        // Load popped element (or zero) and shift toward the lane output
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int k = 0; k <= gi; k++) begin
                    r_sh[k] <= '0;
                end
            end else begin
                r_sh[0] <= w_pop ? w_head_data[gi*CDW +: CDW] : '0;
                for (int k = 1; k <= gi; k++) begin
                    r_sh[k] <= r_sh[k-1];
                end
            end
        end

        assign data_outs[gi] = r_sh[gi];
    end

    // Pop history, registered compute enable and status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld     <= '0;
            r_compute <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_vld[0] <= w_pop;
            for (int k = 1; k < int'(ARRAY_SIZE) - 1; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            r_compute <= w_pop | (|r_vld);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign compute = r_compute;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed testbench for act_skew_feeder (ARRAY_SIZE=2, 4-bit data, FIFO_DEPTH=4).
module tb_act_skew_feeder;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0][3:0] in_data;
    logic            in_last;
    logic            run;
    logic [1:0][3:0] data_outs;
    logic            compute;
    logic            busy;
    logic            done;

    int total;
    int bad;

    act_skew_feeder #(
        .ARRAY_SIZE(2),
        .COMPUTE_DATA_WIDTH(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .run(run),
        .data_outs(data_outs),
        .compute(compute),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       last;
        logic       run;
        logic       rdy;
        logic [3:0] e0;
        logic [3:0] e1;
        logic       c;
        logic       b;
        logic       dn;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] a0,
                                input logic [3:0] a1, input logic l, input logic rn,
                                input logic rdy, input logic [3:0] x0, input logic [3:0] x1,
                                input logic c, input logic b, input logic dn);
        vec_t t;
        t.rst = r;   t.vld = v;  t.d0 = a0;  t.d1 = a1; t.last = l; t.run = rn;
        t.rdy = rdy; t.e0 = x0;  t.e1 = x1;  t.c = c;   t.b = b;    t.dn = dn;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        int pushed;
        int got0;
        int got1;
        int dones;
        total = 0;
        bad   = 0;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; run = 1'b0;

        //            rst vld d0 d1 last run | rdy e0 e1 c b dn
        // single vector {3,5,last}
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 5, 1, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 3, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 5, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));
        // back-to-back batch {1,2},{3,4},{5,6 last}
        tbl.push_back(mk(1, 1, 1, 2, 0, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 4, 0, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 6, 1, 1,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 3, 2, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 5, 4, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 6, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 1));
        // full FIFO with stall, 5th push refused
        tbl.push_back(mk(1, 1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 2, 0, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 3, 0, 0,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 4, 4, 1, 0,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 9, 9, 0, 0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 9, 9, 0, 1,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 2, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 3, 2, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 4, 3, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 4, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 1));
        // bubble between {7,8} and {9,10 last}
        tbl.push_back(mk(1, 1, 7, 8, 0, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 9, 10, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 7, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 8, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 9, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 10, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 1));
        // reset during DRAIN, with a push accepted in DRAIN that must be discarded
        tbl.push_back(mk(1, 1, 1, 2, 1, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 6, 6, 1, 1,  1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 2, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            rst        = tbl[i].rst;
            in_valid   = tbl[i].vld;
            in_data[0] = tbl[i].d0;
            in_data[1] = tbl[i].d1;
            in_last    = tbl[i].last;
            run        = tbl[i].run;
            @(negedge clk);
            total++;
            if (in_ready !== tbl[i].rdy || data_outs[0] !== tbl[i].e0 ||
                data_outs[1] !== tbl[i].e1 || compute !== tbl[i].c ||
                busy !== tbl[i].b || done !== tbl[i].dn) begin
                bad++;
                $display("FAIL row%0d: got rdy=%b d0=%0d d1=%0d cmp=%b busy=%b done=%b want rdy=%b d0=%0d d1=%0d cmp=%b busy=%b done=%b",
                         i, in_ready, data_outs[0], data_outs[1], compute, busy, done,
                         tbl[i].rdy, tbl[i].e0, tbl[i].e1, tbl[i].c, tbl[i].b, tbl[i].dn);
            end
        end

        // wrap-around: ten single-vector batches {k, k+5}, pushed as fast as accepted
        pushed = 0; got0 = 0; got1 = 0; dones = 0;
        for (int cyc = 0; cyc < 400 && dones < 10; cyc++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            run = 1'b1;
            if (pushed < 10) begin
                in_valid   = 1'b1;
                in_data[0] = 4'(pushed + 1);
                in_data[1] = 4'(pushed + 6);
                in_last    = 1'b1;
            end else begin
                in_valid   = 1'b0;
                in_data    = '0;
                in_last    = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) pushed++;
            if (data_outs[0] != 4'd0) begin
                check("wrap_lane0", int'(data_outs[0]), got0 + 1);
                got0++;
            end
            if (data_outs[1] != 4'd0) begin
                check("wrap_lane1", int'(data_outs[1]), got1 + 6);
                got1++;
            end
            if (done) dones++;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("wrap_dones", dones, 10);
        check("wrap_lane0_count", got0, 10);
        check("wrap_lane1_count", got1, 10);
        check("wrap_idle_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
